// File: rtl/seq_detector_prog.sv
// Programmable serial sequence detector with runtime pattern/length/overlap.
// Optional saturating match counter enabled by defining SEQDET_COUNT_EN.
module seq_detector_prog #(
   parameter int unsigned MAX_LEN = 8,
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned LEN_W   = $clog2(MAX_LEN) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic               x,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               cnt_clr,
   output logic               z,
   output logic [CNT_W-1:0]   match_count
);

   localparam logic [LEN_W-1:0]   MAX_LEN_L = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0]   RST_LEN   = LEN_W'(4);
   localparam logic [MAX_LEN-1:0] RST_PAT   = MAX_LEN'(4'b1010);

   logic [MAX_LEN-1:0] hist;
   logic [LEN_W-1:0]   fill;
   logic [MAX_LEN-1:0] pat;
   logic [LEN_W-1:0]   len;
   logic               ovl;

   logic               accept;
   logic               match;
   logic [MAX_LEN-1:0] hist_nxt;
   logic [MAX_LEN-1:0] mask;
   logic [LEN_W:0]     fill_p1;
   logic [LEN_W-1:0]   fill_inc;
   logic [LEN_W-1:0]   len_clamp;
   logic               unused_hist_msb;

   assign unused_hist_msb = hist[MAX_LEN-1];

   // Match evaluation against the history as it will look after this bit
   always_comb begin
      accept   = in_valid & ~cfg_load;
      hist_nxt = {hist[MAX_LEN-2:0], x};
      fill_p1  = {1'b0, fill} + (LEN_W+1)'(1);
      fill_inc = (fill == MAX_LEN_L) ? fill : fill_p1[LEN_W-1:0];
      mask     = '0;
      for (int i = 0; i < int'(MAX_LEN); i++) begin
         mask[i] = (LEN_W'(i) < len);
      end
      match = accept && (fill_p1 >= {1'b0, len}) &&
              (((hist_nxt ^ pat) & mask) == '0);
      if (cfg_len == '0) begin
         len_clamp = LEN_W'(1);
      end else if (cfg_len > MAX_LEN_L) begin
         len_clamp = MAX_LEN_L;
      end else begin
         len_clamp = cfg_len;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist <= '0;
         fill <= '0;
         z    <= 1'b0;
         pat  <= RST_PAT;
         len  <= RST_LEN;
         ovl  <= 1'b0;
      end else if (cfg_load) begin
         pat  <= cfg_pattern;
         len  <= len_clamp;
         ovl  <= cfg_overlap;
         hist <= '0;
         fill <= '0;
         z    <= 1'b0;
      end else if (accept) begin
         hist <= hist_nxt;
         // Non-overlapping mode demands len fresh bits before the next match
         fill <= (match && !ovl) ? '0 : fill_inc;
         z    <= match;
      end else begin
         z    <= 1'b0;
      end
   end

`ifdef SEQDET_COUNT_EN
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (cnt_clr) begin
         cnt <= match ? CNT_W'(1) : '0;
      end else if (match && (cnt != '1)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign match_count = cnt;
`else
   logic unused_cnt_clr;

   assign unused_cnt_clr = cnt_clr;
   assign match_count    = '0;
`endif

endmodule
